// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu program sequencer.
package cpu_seq_pkg;

    localparam int CMD_W = 32;
    localparam int ID_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_END  = 2'd3
    } seq_state_e;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_TMO  = 2'd1;
    localparam logic [1:0] ST_BADF = 2'd2;
    localparam logic [1:0] ST_ABRT = 2'd3;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program store: DEPTH x CMD_W words, one synchronous write port and one
// registered read port. The array has no reset; only the read register does,
// so the word presented to the core is 0 out of reset.
module cpu_prog_mem
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [CMD_W-1:0] rd_data
);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [CMD_W-1:0] rd_data_d;
    logic [CMD_W-1:0] rd_data_q;

    // Write port: contents survive sys_rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next read word: clear wins over a fetch, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cpu_prog_sequencer.sv
// Program sequencer for the cpu core: holds the program store, pulses the
// core reset at run start, serves instruction fetches during the run and ends
// the run on a result, a fetch outside the store, a timeout or an abort.
module cpu_prog_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter int RST_CYC  = 2,
    parameter int WDOG_CYC = 100000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [31:0]   result,
    output logic          cpu_rst_n,
    output logic [31:0]   cmd,
    output logic          cmd_en,
    input  logic [15:0]   cmd_id,
    input  logic [31:0]   res,
    input  logic          res_en
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    seq_state_e        state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [1:0]        status_q, status_d;
    logic [CMD_W-1:0]  result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              cmd_en_q, cmd_en_d;

    logic              mem_we;
    logic              mem_rd_en;
    logic              mem_rd_clr;
    logic              bad_fetch;
    logic              run_exit;

    assign bad_fetch = (cmd_id >= ID_W'(DEPTH));

    cpu_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .we      (mem_we),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .rd_addr (cmd_id[AW-1:0]),
        .rd_data (cmd)
    );

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wdog_d      = wdog_q;
        status_d    = status_q;
        result_d    = result_q;
        cpu_rst_n_d = cpu_rst_n_q;
        cmd_en_d    = cmd_en_q;
        done_d      = 1'b0;
        mem_we      = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_clr  = 1'b0;
        run_exit    = 1'b0;

        case (state_q)
            S_IDLE, S_END: begin
                // The store is writable only between runs.
                mem_we = ld_we;
                if (abort) begin
                    state_d     = S_IDLE;
                    cpu_rst_n_d = 1'b0;
                    cmd_en_d    = 1'b0;
                end else if (start) begin
                    state_d     = S_RST;
                    rst_cnt_d   = RC_W'(RST_CYC - 1);
                    wdog_d      = '0;
                    status_d    = ST_OK;
                    result_d    = '0;
                    cpu_rst_n_d = 1'b0;
                    cmd_en_d    = 1'b0;
                end
            end

            S_RST: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    cpu_rst_n_d = 1'b0;
                    cmd_en_d    = 1'b0;
                end else if (rst_cnt_q == '0) begin
                    state_d     = S_RUN;
                    cpu_rst_n_d = 1'b1;
                    cmd_en_d    = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end

            S_RUN: begin
                // Fetch every cycle; an out-of-store index presents 0.
                mem_rd_en  = 1'b1;
                mem_rd_clr = bad_fetch;
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
                if (abort) begin
                    // Abandoned runs keep the core in reset afterwards.
                    status_d    = ST_ABRT;
                    cpu_rst_n_d = 1'b0;
                    run_exit    = 1'b1;
                end else if (res_en) begin
                    result_d = res;
                    status_d = ST_OK;
                    run_exit = 1'b1;
                end else if (bad_fetch) begin
                    status_d = ST_BADF;
                    run_exit = 1'b1;
                end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                    status_d = ST_TMO;
                    run_exit = 1'b1;
                end
                if (run_exit) begin
                    state_d  = S_END;
                    cmd_en_d = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RST) || (state_d == S_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            wdog_q      <= '0;
            status_q    <= ST_OK;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            cmd_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wdog_q      <= wdog_d;
            status_q    <= status_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            cmd_en_q    <= cmd_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign result    = result_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign cmd_en    = cmd_en_q;

endmodule
